// File: rtl/seq_uart_pkg.sv
// rtl/seq_uart_pkg.sv - shared constants and state encoding for the sequencer UART transmitter
//
// Purpose : Single home for the constants shared by the UART serializer files.
// Contents:
//   SEQ_DP_WIDTH       sequencer datapath width, default payload width per frame
//   UART_CLKS_PER_BIT  default clk cycles per bit (100 MHz / 115200 baud)
//   uart_state_e       frame FSM state encoding
//   uart_frame_cycles  busy-cycle count of one frame for a given width/bit period
package seq_uart_pkg;

    localparam int SEQ_DP_WIDTH      = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // One start bit, data_w data bits and one stop bit, each clks cycles long.
    function automatic int uart_frame_cycles(input int data_w, input int clks);
        return (data_w + 2) * clks;
    endfunction

endpackage

// File: rtl/seq_uart_baud.sv
// rtl/seq_uart_baud.sv - bit-period counter producing one tick per UART bit
//
// Purpose : Counts 0..CLKS_PER_BIT-1 while i_run is high and flags the last
//           cycle of every bit period. The count is held at zero while idle so
//           every frame starts on a fresh, full-length bit period.
// Ports   :
//   clk     in  1  system clock, rising edge
//   rst     in  1  synchronous active-high reset
//   i_run   in  1  high while a frame is in progress; low clears the counter
//   o_tick  out 1  one-cycle pulse on the final cycle of each bit period
module seq_uart_baud
    import seq_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_tick
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    // The tick is decoded straight from the counter flop, so it is aligned
    // with the cycle in which the FSM must decide the next line level.
    assign o_tick = i_run && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_run) begin
            cnt_d = '0;
        end else if (at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_uart_tx.sv
// rtl/seq_uart_tx.sv - 8N1 UART serializer on the sequencer send port
//
// Purpose : Accepts one word per valid/busy handshake and sends it as a
//           start bit, DATA_W data bits (LSB first) and one stop bit.
// Ports   :
//   clk         in  1       system clock, rising edge
//   rst         in  1       synchronous active-high reset; aborts any frame
//   i_tx_data   in  DATA_W  word to send, sampled only on accept
//   i_tx_valid  in  1       level send request, may be combinational
//   o_tx_busy   out 1       registered, high while a frame is in progress
//   o_txd       out 1       registered serial line, idle high
module seq_uart_tx
    import seq_uart_pkg::*;
#(
    parameter int DATA_W       = SEQ_DP_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_busy,
    output logic              o_txd
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    uart_state_e       state_q;
    uart_state_e       state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  bit_idx_d;
    logic [IDX_W-1:0]  bit_idx_nxt;
    logic              txd_q;
    logic              txd_d;
    logic              busy_q;
    logic              busy_d;

    logic              baud_run;
    logic              bit_tick;

    // The counter runs for every non-idle state, so it restarts at zero on
    // the cycle right after an accept and wraps on every bit boundary.
    assign baud_run = (state_q != UART_IDLE);

    seq_uart_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_run  (baud_run),
        .o_tick (bit_tick)
    );

    assign bit_idx_nxt = bit_idx_q + IDX_W'(1);

    // Next-state logic. The line level for the coming bit period is computed
    // here and registered, so o_txd only moves on bit boundaries and never
    // passes through combinational decode on its way to the pin.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        busy_d    = busy_q;

        case (state_q)
            UART_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (i_tx_valid && !busy_q) begin
                    shift_d   = i_tx_data;
                    bit_idx_d = '0;
                    state_d   = UART_START;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            UART_START: begin
                if (bit_tick) begin
                    state_d   = UART_DATA;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end
            end

            UART_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = UART_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_nxt;
                        txd_d     = shift_q[bit_idx_nxt];
                    end
                end
            end

            UART_STOP: begin
                // Busy drops with the stop bit's last edge, so the next
                // accept can happen no earlier than the following cycle.
                if (bit_tick) begin
                    state_d = UART_IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = UART_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UART_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    assign o_txd     = txd_q;
    assign o_tx_busy = busy_q;

endmodule

// File: tb/tb_seq_uart_tx.sv
// tb/tb_seq_uart_tx.sv - self-checking bench for seq_uart_tx at 4 and 2 clks per bit
module tb_seq_uart_tx;

    typedef logic lvl_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       txd4;
    logic       busy4;
    logic       txd2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    lvl_q_t q4;
    lvl_q_t q2;
    int     busy_cnt4;
    int     busy_cnt2;

    always #5 clk = ~clk;

    seq_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_busy  (busy4),
        .o_txd      (txd4)
    );

    seq_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_busy  (busy2),
        .o_txd      (txd2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line levels of one whole frame, one entry per clk cycle.
    function automatic lvl_q_t frame_levels(input logic [7:0] d, input int c);
        lvl_q_t f;
        logic   lvl;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      lvl = 1'b0;
            else if (b == 9) lvl = 1'b1;
            else             lvl = d[b-1];
            for (int r = 0; r < c; r++) f.push_back(lvl);
        end
        return f;
    endfunction

    // One clock: advance both reference line queues at the edge, then
    // compare both DUTs against the queue heads on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            q4.delete();
            q2.delete();
        end else begin
            if (q4.size() != 0) void'(q4.pop_front());
            else if (tx_valid) q4 = frame_levels(tx_data, 4);
            if (q2.size() != 0) void'(q2.pop_front());
            else if (tx_valid) q2 = frame_levels(tx_data, 2);
        end
        @(negedge clk);
        check_val("txd4",  txd4,  (q4.size() == 0) ? 1'b1 : q4[0]);
        check_val("busy4", busy4, (q4.size() != 0));
        check_val("txd2",  txd2,  (q2.size() == 0) ? 1'b1 : q2[0]);
        check_val("busy2", busy2, (q2.size() != 0));
        if (busy4) busy_cnt4++;
        if (busy2) busy_cnt2++;
    endtask

    initial begin
        int  rise_at;
        int  idle_cnt;
        bit  seen_low;

        busy_cnt4 = 0;
        busy_cnt2 = 0;

        // Reset held with valid high: nothing may start.
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        repeat (3) cycle();
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (3) cycle();

        // Single frame 0xA5.
        tx_data   = 8'hA5;
        tx_valid  = 1'b1;
        busy_cnt4 = 0;
        busy_cnt2 = 0;
        cycle();
        tx_valid = 1'b0;
        repeat (44) cycle();
        check_val("a5_busy_len4", busy_cnt4, 40);
        check_val("a5_busy_len2", busy_cnt2, 20);

        // Back-to-back 0x00 then 0xFF with valid held.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        cycle();
        tx_data  = 8'hFF;
        rise_at  = 0;
        idle_cnt = 0;
        seen_low = 1'b0;
        for (int i = 2; i <= 60; i++) begin
            cycle();
            if (!busy4 && rise_at == 0) begin
                seen_low = 1'b1;
                idle_cnt++;
            end
            if (seen_low && busy4 && rise_at == 0) rise_at = i;
        end
        check_val("b2b_second_start", rise_at, 42);
        check_val("b2b_idle_gap", idle_cnt, 1);
        tx_valid = 1'b0;
        repeat (100) cycle();

        // Valid pulse and data change mid-frame are ignored.
        tx_data   = 8'h12;
        tx_valid  = 1'b1;
        busy_cnt4 = 0;
        busy_cnt2 = 0;
        cycle();
        tx_valid = 1'b0;
        repeat (8) cycle();
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        cycle();
        tx_valid = 1'b0;
        repeat (40) cycle();
        check_val("ignore_busy_len4", busy_cnt4, 40);
        check_val("ignore_busy_len2", busy_cnt2, 20);

        // Reset while the 4-clk instance is in data bit 3.
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        cycle();
        tx_valid = 1'b0;
        repeat (17) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("rst_mid_txd4",  txd4,  1);
        check_val("rst_mid_busy4", busy4, 0);
        tx_data   = 8'h81;
        tx_valid  = 1'b1;
        busy_cnt4 = 0;
        busy_cnt2 = 0;
        cycle();
        tx_valid = 1'b0;
        repeat (44) cycle();
        check_val("after_rst_len4", busy_cnt4, 40);
        check_val("after_rst_len2", busy_cnt2, 20);

        // 2-clk boundary with alternating pattern.
        tx_data   = 8'h55;
        tx_valid  = 1'b1;
        busy_cnt2 = 0;
        cycle();
        tx_valid = 1'b0;
        repeat (44) cycle();
        check_val("b55_busy_len2", busy_cnt2, 20);

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            rst      = ($urandom_range(0, 299) == 0);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            cycle();
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (50) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_uart_tx.md
Name: seq_uart_tx

Overview:
UART serializer that sits on the sequencer's send port.
- Accepts one data word per handshake from the sequencer: data, valid, busy.
- Transmits the word as a standard 8N1 asynchronous frame on a single line.
- Drives busy back to the sequencer so that no send is issued while a frame is in flight.

Parameters:
DATA_W, 8, payload width per frame; equals seq_dp_width.
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200 baud); legal range >= 2.
CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter; derived, never overridden.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
i_tx_data  in  DATA_W  word to send; sampled only on accept.
i_tx_valid  in  1  send request, level-sensitive; may be combinational from the sequencer.
o_tx_busy  out  1  registered; high while a frame is in progress.
o_txd  out  1  registered serial line, idle high.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: o_txd=1, o_tx_busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset mid-frame:
  - Frame is aborted on the next edge; o_txd=1 and o_tx_busy=0 after that edge.
  - No partial data or stop bit is completed.
- Accept: an edge where i_tx_valid=1, o_tx_busy=0 and state=IDLE.
  - i_tx_data is captured into the shift register.
  - State goes to START; o_txd=0 and o_tx_busy=1 from the next cycle.
- While busy:
  - i_tx_valid is ignored (not queued, not counted).
  - Changes on i_tx_data have no effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_txd=1, busy=0. Wait for accept.
  - START: o_txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_txd = shift[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit DATA_W-1, go to STOP.
  - STOP: o_txd=1 for CLKS_PER_BIT cycles, then go to IDLE with busy=0.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit period.
  - Wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
- Frame length: exactly (DATA_W+2)*CLKS_PER_BIT cycles of busy=1 per accept.
- Back-to-back sends:
  - The earliest next accept is the first IDLE cycle.
  - The line therefore sees one idle-high clk cycle plus the full stop bit between frames.
- Simultaneous rst and i_tx_valid: reset wins and nothing is accepted.
- o_txd changes only on bit boundaries; it is glitch-free because it comes straight from a flop.

Decomposition:
- Shared include seq_definitions.v: seq_dp_width, which is the DATA_W default.
- New shared constants: uart state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) and the default CLKS_PER_BIT.
- One sub-module, seq_uart_baud:
  - Parameterised bit-period counter with inputs clk, rst, i_run.
  - Output o_tick, a one-cycle pulse on the last cycle of each bit period.
  - Counter clears while i_run=0.
- FSM, shift register and bit index stay in seq_uart_tx.

Test Plan:
1. Reset check, CLKS_PER_BIT=4: assert rst for 3 cycles with i_tx_valid=1 -> o_txd=1, o_tx_busy=0 throughout; nothing transmitted after release unless valid is still high.
2. Single frame, CLKS_PER_BIT=4, send 0xA5 -> starting one cycle after accept, o_txd = 0 (4 clk), then 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk); busy high for exactly 40 cycles.
3. Back-to-back, 0x00 then 0xFF with valid held high -> second start bit begins 42 cycles after the first accept; the second frame's data bits are all 1.
4. Valid pulse at cycle 10 of a frame with data 0x3C -> ignored: exactly one frame is sent; i_tx_data changing to 0x3C mid-frame does not alter o_txd.
5. Reset during DATA bit 3 -> o_txd=1 and busy=0 on the edge after reset; a new 0x81 accepted afterwards produces a clean full frame.
6. CLKS_PER_BIT=2 boundary case: send 0x55 -> 20 busy cycles; o_txd alternates every 2 cycles across the data bits.
